// File: rtl/id_ex_stage.sv
// id_ex_stage: one-entry ID/EX pipeline register with valid/ready handshake
// and combinational EX/MEM, MEM/WB operand forwarding on the held entry.
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic [4:0]      rd_addr,
    input  logic [3:0]      alu_control,
    input  logic            alu_src_a,
    input  logic            alu_src_b,
    input  logic            reg_write,
    input  logic [4:0]      exmem_rd,
    input  logic            exmem_reg_write,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [4:0]      memwb_rd,
    input  logic            memwb_reg_write,
    input  logic [XLEN-1:0] memwb_result,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_control_o,
    output logic [4:0]      rd_o,
    output logic            reg_write_o,
    output logic [XLEN-1:0] store_data
);
    logic [XLEN-1:0] pc_q, rs1_q, rs2_q, imm_q, fwd1, fwd2;
    logic [4:0]      rs1a_q, rs2a_q, rd_q;
    logic [3:0]      ctl_q;
    logic            srca_q, srcb_q, rw_q;

    assign in_ready = (!out_valid || out_ready) && !flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            pc_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            rs1a_q    <= '0;
            rs2a_q    <= '0;
            rd_q      <= '0;
            ctl_q     <= '0;
            srca_q    <= 1'b0;
            srcb_q    <= 1'b0;
            rw_q      <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            pc_q      <= pc;
            rs1_q     <= rs1_data;
            rs2_q     <= rs2_data;
            imm_q     <= imm;
            rs1a_q    <= rs1_addr;
            rs2a_q    <= rs2_addr;
            rd_q      <= rd_addr;
            ctl_q     <= alu_control;
            srca_q    <= alu_src_a;
            srcb_q    <= alu_src_b;
            rw_q      <= reg_write;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // EX/MEM is the younger producer so it wins; x0 is never forwarded
    assign fwd1 = (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == rs1a_q) ? exmem_result :
                  (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == rs1a_q) ? memwb_result : rs1_q;
    assign fwd2 = (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == rs2a_q) ? exmem_result :
                  (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == rs2a_q) ? memwb_result : rs2_q;

    assign alu_a         = srca_q ? pc_q : fwd1;
    assign alu_b         = srcb_q ? imm_q : fwd2;
    assign store_data    = fwd2;
    assign alu_control_o = ctl_q;
    assign rd_o          = rd_q;
    assign reg_write_o   = rw_q && out_valid;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed, self-checking bench for id_ex_stage.
module tb_id_ex_stage;
    localparam int XLEN = 32;
    logic            clk = 1'b0, reset_n, in_valid, in_ready, flush;
    logic [XLEN-1:0] pc, rs1_data, rs2_data, imm, exmem_result, memwb_result;
    logic [4:0]      rs1_addr, rs2_addr, rd_addr, exmem_rd, memwb_rd, rd_o;
    logic [3:0]      alu_control, alu_control_o;
    logic            alu_src_a, alu_src_b, reg_write, exmem_reg_write, memwb_reg_write;
    logic            out_ready, out_valid, reg_write_o;
    logic [XLEN-1:0] alu_a, alu_b, store_data;
    int checks = 0, errors = 0;

    id_ex_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr), .alu_control(alu_control),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_write(reg_write),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
        .out_ready(out_ready), .out_valid(out_valid), .alu_a(alu_a), .alu_b(alu_b),
        .alu_control_o(alu_control_o), .rd_o(rd_o), .reg_write_o(reg_write_o), .store_data(store_data)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [XLEN-1:0] r1, input logic [XLEN-1:0] r2, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [4:0] rd, input logic [3:0] ctl, input logic rw);
        rs1_data = r1; rs2_data = r2; rs1_addr = a1; rs2_addr = a2; rd_addr = rd;
        alu_control = ctl; reg_write = rw; pc = '0; imm = '0; alu_src_a = 0; alu_src_b = 0;
        in_valid = 1;
    endtask

    task automatic test_reset;
        reset_n = 0; flush = 0; in_valid = 0; out_ready = 0;
        offer('0, '0, 0, 0, 0, 0, 0); in_valid = 0;
        exmem_rd = 0; exmem_reg_write = 0; exmem_result = '0;
        memwb_rd = 0; memwb_reg_write = 0; memwb_result = '0;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (alu_a !== '0) begin errors++; $display("FAIL reset_alu_a: got %h want 0", alu_a); end
        checks++; if (alu_b !== '0) begin errors++; $display("FAIL reset_alu_b: got %h want 0", alu_b); end
        checks++; if (store_data !== '0) begin errors++; $display("FAIL reset_store_data: got %h want 0", store_data); end
        checks++; if (alu_control_o !== 4'd0) begin errors++; $display("FAIL reset_alu_control: got %h want 0", alu_control_o); end
        checks++; if (rd_o !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d want 0", rd_o); end
        checks++; if (reg_write_o !== 1'b0) begin errors++; $display("FAIL reset_reg_write: got %b want 0", reg_write_o); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        #5 reset_n = 1;
        tick;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got %b want 0", out_valid); end
    endtask

    task automatic test_pass_through;
        offer(5, 3, 1, 2, 7, 4'b0001, 1);
        tick;
        in_valid = 0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pt_out_valid: got %b want 1", out_valid); end
        checks++; if (alu_a !== 32'd5) begin errors++; $display("FAIL pt_alu_a: got %h want 5", alu_a); end
        checks++; if (alu_b !== 32'd3) begin errors++; $display("FAIL pt_alu_b: got %h want 3", alu_b); end
        checks++; if (rd_o !== 5'd7) begin errors++; $display("FAIL pt_rd: got %0d want 7", rd_o); end
        checks++; if (reg_write_o !== 1'b1) begin errors++; $display("FAIL pt_reg_write: got %b want 1", reg_write_o); end
        checks++; if (alu_control_o !== 4'b0001) begin errors++; $display("FAIL pt_alu_control: got %h want 1", alu_control_o); end
        // pc/imm operand select, store_data stays the rs2 value
        offer(32'h1, 32'h9, 1, 2, 6, 4'b1001, 0);
        pc = 32'h100; imm = 32'h20; alu_src_a = 1; alu_src_b = 1; out_ready = 1;
        tick;
        in_valid = 0; out_ready = 0;
        checks++; if (alu_a !== 32'h100) begin errors++; $display("FAIL sel_alu_a: got %h want 100", alu_a); end
        checks++; if (alu_b !== 32'h20) begin errors++; $display("FAIL sel_alu_b: got %h want 20", alu_b); end
        checks++; if (store_data !== 32'h9) begin errors++; $display("FAIL sel_store_data: got %h want 9", store_data); end
        checks++; if (reg_write_o !== 1'b0) begin errors++; $display("FAIL sel_reg_write: got %b want 0", reg_write_o); end
    endtask

    task automatic test_forward;
        offer(32'h11, 32'h22, 4, 5, 3, 0, 1); out_ready = 1;
        tick;
        in_valid = 0; out_ready = 0;
        exmem_rd = 4; exmem_reg_write = 1; exmem_result = 32'hAA;
        memwb_rd = 4; memwb_reg_write = 1; memwb_result = 32'hBB;
        #1;
        checks++; if (alu_a !== 32'hAA) begin errors++; $display("FAIL fwd_exmem_priority: got %h want aa", alu_a); end
        exmem_reg_write = 0; #1;
        checks++; if (alu_a !== 32'hBB) begin errors++; $display("FAIL fwd_memwb: got %h want bb", alu_a); end
        memwb_rd = 5; #1;
        checks++; if (store_data !== 32'hBB) begin errors++; $display("FAIL fwd_rs2_store: got %h want bb", store_data); end
        checks++; if (alu_a !== 32'h11) begin errors++; $display("FAIL fwd_none: got %h want 11", alu_a); end
        memwb_reg_write = 0;
        offer(32'h33, 32'h44, 0, 0, 2, 0, 1); out_ready = 1;
        tick;
        in_valid = 0; out_ready = 0;
        exmem_rd = 0; exmem_reg_write = 1; memwb_rd = 0; memwb_reg_write = 1; #1;
        checks++; if (alu_a !== 32'h33) begin errors++; $display("FAIL fwd_x0_rs1: got %h want 33", alu_a); end
        checks++; if (alu_b !== 32'h44) begin errors++; $display("FAIL fwd_x0_rs2: got %h want 44", alu_b); end
        exmem_reg_write = 0; memwb_reg_write = 0;
    endtask

    task automatic test_stall;
        offer(32'h44, 32'h0, 6, 0, 8, 0, 1); out_ready = 1;
        tick;
        out_ready = 0;
        offer(32'h55, 32'h0, 1, 0, 9, 0, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready); end
            checks++; if (rd_o !== 5'd8 || alu_a !== 32'h44 || out_valid !== 1'b1) begin
                errors++; $display("FAIL stall_hold[%0d]: got rd=%0d a=%h v=%b want rd=8 a=44 v=1", i, rd_o, alu_a, out_valid); end
            tick;
        end
        exmem_rd = 6; exmem_reg_write = 1; exmem_result = 32'h77; #1;
        checks++; if (alu_a !== 32'h77) begin errors++; $display("FAIL stall_fwd_a: got %h want 77", alu_a); end
        exmem_result = 32'h78; #1;
        checks++; if (alu_a !== 32'h78) begin errors++; $display("FAIL stall_fwd_b: got %h want 78", alu_a); end
        exmem_reg_write = 0; out_ready = 1;
        tick;
        in_valid = 0; out_ready = 0;
        checks++; if (rd_o !== 5'd9 || alu_a !== 32'h55 || out_valid !== 1'b1) begin
            errors++; $display("FAIL stall_release: got rd=%0d a=%h v=%b want rd=9 a=55 v=1", rd_o, alu_a, out_valid); end
    endtask

    task automatic test_back_to_back;
        out_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            offer(i, 0, 0, 0, 5'(i), 0, 1);
            tick;
            checks++; if (out_valid !== 1'b1 || rd_o !== 5'(i)) begin
                errors++; $display("FAIL b2b[%0d]: got v=%b rd=%0d want v=1 rd=%0d", i, out_valid, rd_o, i); end
        end
        in_valid = 0;
        tick;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
        checks++; if (reg_write_o !== 1'b0) begin errors++; $display("FAIL b2b_bubble_rw: got %b want 0", reg_write_o); end
        out_ready = 0;
    endtask

    task automatic test_flush;
        offer(32'h1, 32'h2, 0, 0, 3, 0, 1);
        tick;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre: got %b want 1", out_valid); end
        offer(32'h5, 32'h6, 0, 0, 12, 0, 1); flush = 1; out_ready = 1; #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
        tick;
        flush = 0; in_valid = 0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
        checks++; if (reg_write_o !== 1'b0) begin errors++; $display("FAIL flush_reg_write: got %b want 0", reg_write_o); end
        tick;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped: got %b want 0", out_valid); end
        out_ready = 0;
    endtask

    task automatic test_async_reset;
        offer(32'h99, 32'h0, 0, 0, 5, 4'b0011, 1);
        tick;
        in_valid = 0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL areset_pre: got %b want 1", out_valid); end
        #2 reset_n = 0;
        #1;
        checks++; if (out_valid !== 1'b0 || alu_a !== '0) begin
            errors++; $display("FAIL areset_clear: got v=%b a=%h want v=0 a=0", out_valid, alu_a); end
        checks++; if (rd_o !== 5'd0 || alu_control_o !== 4'd0) begin
            errors++; $display("FAIL areset_payload: got rd=%0d ctl=%h want 0 0", rd_o, alu_control_o); end
        #1 reset_n = 1;
        offer(32'h12, 32'h0, 0, 0, 10, 0, 1);
        tick;
        in_valid = 0;
        checks++; if (out_valid !== 1'b1 || alu_a !== 32'h12 || rd_o !== 5'd10) begin
            errors++; $display("FAIL areset_reload: got v=%b a=%h rd=%0d want 1 12 10", out_valid, alu_a, rd_o); end
    endtask

    initial begin
        test_reset;
        test_pass_through;
        test_forward;
        test_stall;
        test_back_to_back;
        test_flush;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  decode offers an instruction.
REQ-005 in_ready  output  1  stage accepts the offered instruction this cycle.
REQ-006 flush  input  1  kill the held instruction and drop any offered one.
REQ-007 pc, rs1_data, rs2_data, imm  input  XLEN each  decoded operands.
REQ-008 rs1_addr, rs2_addr, rd_addr  input  5 each  register indices.
REQ-009 alu_control  input  4  ALU opcode (0000 ADD ... 1001 AND).
REQ-010 alu_src_a  input  1  1 = use pc as operand A; alu_src_b  input  1  1 = use imm as operand B.
REQ-011 reg_write  input  1  instruction writes rd.
REQ-012 exmem_rd  input  5, exmem_reg_write  input  1, exmem_result  input  XLEN  EX/MEM forward source.
REQ-013 memwb_rd  input  5, memwb_reg_write  input  1, memwb_result  input  XLEN  MEM/WB forward source.
REQ-014 out_ready  input  1  ALU/EX side consumes the held instruction.
REQ-015 out_valid  output  1  held instruction is valid.
REQ-016 alu_a, alu_b  output  XLEN  ALU operands; alu_control_o  output  4; rd_o  output  5; reg_write_o  output  1.
REQ-017 store_data  output  XLEN  forwarded rs2 value, independent of alu_src_b.

Function
REQ-018 SHALL hold one instruction entry: all input payload fields plus a valid bit.
REQ-019 in_ready SHALL equal (!out_valid || out_ready) && !flush, combinationally.
REQ-020 Load: in_valid && in_ready at edge SHALL capture all payload and set out_valid=1 next cycle (latency 1).
REQ-021 out_ready && out_valid && no load at edge SHALL clear out_valid; payload registers hold.
REQ-022 Simultaneous consume and load SHALL replace entry with no bubble (full throughput, 1 instr/cycle).
REQ-023 out_valid && !out_ready SHALL hold every output stable (stall).
REQ-024 flush at edge SHALL clear out_valid, block load, regardless of in_valid/out_ready; flush beats load.
REQ-025 Forwarding SHALL be combinational on held rs1_addr/rs2_addr each cycle, so a stalled entry sees updated forward buses.
REQ-026 fwd rs value: if exmem_reg_write && exmem_rd!=0 && exmem_rd==rs -> exmem_result; else if memwb_reg_write && memwb_rd!=0 && memwb_rd==rs -> memwb_result; else held rsN_data.
REQ-027 EX/MEM SHALL take priority over MEM/WB when both match.
REQ-028 Register x0 SHALL never be forwarded; rs addr 0 yields held data.
REQ-029 alu_a = alu_src_a ? held pc : fwd rs1; alu_b = alu_src_b ? held imm : fwd rs2; store_data = fwd rs2.
REQ-030 reg_write_o SHALL equal held reg_write && out_valid (no write from a bubble).
REQ-031 alu_control_o, rd_o SHALL reflect held fields unmodified; no arithmetic performed in this block.

Reset
REQ-032 reset_n low SHALL immediately clear out_valid and all payload registers to 0, asynchronously.
REQ-033 During and after reset, until first load: alu_a=0, alu_b=0, store_data=0, alu_control_o=0000, rd_o=0, reg_write_o=0, in_ready=1 (when flush=0).
REQ-034 Reset deassertion SHALL take effect on the next rising clk; reset mid-stall SHALL discard the held entry.

Verification
REQ-035 Pass-through: load rs1_data=5, rs2_data=3, alu_control=0001, rd=7, reg_write=1, no hazards -> next cycle out_valid=1, alu_a=5, alu_b=3, rd_o=7, reg_write_o=1.
REQ-036 Forward priority: held rs1_addr=4; exmem_rd=4 result 0xAA, memwb_rd=4 result 0xBB, both writes=1 -> alu_a=0xAA; drop exmem_reg_write -> alu_a=0xBB; rs1_addr=0 with matching rd=0 -> held data.
REQ-037 Stall: out_valid=1, out_ready=0 for 3 cycles, in_valid=1 -> in_ready=0, outputs constant; change exmem_result while matching -> alu_a tracks it; out_ready=1 -> new entry loaded next cycle.
REQ-038 Back-to-back: in_valid=out_ready=1 for 4 cycles with distinct rd 1..4 -> rd_o sequence 1,2,3,4 with no bubble.
REQ-039 Flush: out_valid=1, flush=1, in_valid=1, out_ready=1 -> next cycle out_valid=0, reg_write_o=0, offered instruction dropped.
REQ-040 Async reset: assert reset_n=0 between edges while out_valid=1 -> out_valid=0 and alu_a=0 before next clk edge.
